// File: rtl/rgb_fade_sequencer_if.sv
// Target load port of the RGB fade sequencer.
//   tgt_valid : source offers a target color
//   tgt_ready : sequencer accepts it (only while idle and out of reset)
//   tgt_rgb   : target color {r[23:16], g[15:8], b[7:0]}
// master = target source, slave = sequencer.
interface rgb_fade_sequencer_if;
   logic        tgt_valid;
   logic        tgt_ready;
   logic [23:0] tgt_rgb;

   modport master (output tgt_valid, output tgt_rgb, input tgt_ready);
   modport slave  (input tgt_valid, input tgt_rgb, output tgt_ready);
endinterface

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: ramps the current duty values one LSB per step toward a
// target color, holds the target for HOLD_STEPS steps, then pulses done.
// Targets come from the load port or, with auto_en, from an 8-entry palette.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   ld       target load port (valid/ready, 24-bit color)
//   auto_en  cycle through the palette while idle
//   r_out/g_out/b_out  current duty values to the RGB controller
//   busy     high in RAMP or HOLD
//   done     one-cycle pulse on HOLD -> IDLE
//   pal_idx  next palette entry to be auto-loaded
//
// state | meaning
// IDLE  | waiting for an external target or an auto palette load
// RAMP  | stepping each channel toward tgt once per STEP_DIV cycles
// HOLD  | target reached, holding it for HOLD_STEPS steps
module rgb_fade_sequencer #(
   parameter int STEP_DIV   = 1_000_000,
   parameter int HOLD_STEPS = 100
) (
   input  logic                       clk,
   input  logic                       rst,
   rgb_fade_sequencer_if.slave        ld,
   input  logic                       auto_en,
   output logic [7:0]                 r_out,
   output logic [7:0]                 g_out,
   output logic [7:0]                 b_out,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 pal_idx
);
   localparam int CNT_W  = $clog2(STEP_DIV);
   localparam int HCNT_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

   typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

   state_t            state;
   logic [23:0]       tgt;
   logic [CNT_W-1:0]  cnt;
   logic [HCNT_W-1:0] hcnt;
   logic              tick;
   logic              at_tgt;

   function automatic logic [23:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    palette = 24'hFF0000;
         3'd1:    palette = 24'hFFFF00;
         3'd2:    palette = 24'h00FF00;
         3'd3:    palette = 24'h00FFFF;
         3'd4:    palette = 24'h0000FF;
         3'd5:    palette = 24'hFF00FF;
         3'd6:    palette = 24'hFFFFFF;
         default: palette = 24'h000000;
      endcase
   endfunction

   // Move one LSB toward the target; a channel already there stays put, so
   // the increment/decrement can never wrap.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] dst);
      if (cur < dst)
         step_toward = cur + 8'd1;
      else if (cur > dst)
         step_toward = cur - 8'd1;
      else
         step_toward = cur;
   endfunction

   assign ld.tgt_ready = (state == IDLE) && !rst;
   assign tick         = (cnt == CNT_W'(STEP_DIV - 1));
   assign at_tgt       = ({r_out, g_out, b_out} == tgt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tgt     <= '0;
         cnt     <= '0;
         hcnt    <= '0;
         r_out   <= '0;
         g_out   <= '0;
         b_out   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pal_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // External load wins over the palette and leaves pal_idx alone.
               if (ld.tgt_valid) begin
                  tgt   <= ld.tgt_rgb;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RAMP;
               end else if (auto_en) begin
                  tgt     <= palette(pal_idx);
                  pal_idx <= pal_idx + 3'd1;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RAMP;
               end
            end
            RAMP: begin
               // Equality is evaluated on the registered outputs, so a step
               // that lands on the target is seen one cycle later.
               if (at_tgt) begin
                  cnt   <= '0;
                  hcnt  <= '0;
                  state <= HOLD;
               end else if (tick) begin
                  cnt   <= '0;
                  r_out <= step_toward(r_out, tgt[23:16]);
                  g_out <= step_toward(g_out, tgt[15:8]);
                  b_out <= step_toward(b_out, tgt[7:0]);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (tick) begin
                  cnt <= '0;
                  if (hcnt == HCNT_W'(HOLD_STEPS - 1)) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     hcnt <= hcnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Sequences the RGB PWM datapath by supplying the 8-bit red, green and blue duty values that feed the existing RGB controller. It ramps the current color one LSB per step toward a target color, holds the target for a fixed time, then reports completion. Targets come from an external valid/ready load port or, when auto mode is enabled, from an internal 8-entry palette. The block sits between the switch/user logic and the RGB controller in the top level.

## Interface
- STEP_DIV, 1_000_000: clock cycles per ramp/hold step (10 ms at 100 MHz); legal range ≥ 2
- HOLD_STEPS, 100: steps the target color is held before done; legal range ≥ 1
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- tgt_valid  in  1  external target offered
- tgt_ready  out  1  block accepts target; equals (state==IDLE) && !RST
- tgt_rgb  in  24  target {r[23:16], g[15:8], b[7:0]}
- auto_en  in  1  enables palette cycling while IDLE
- r_out, g_out, b_out  out  8 each  current duty values to the RGB controller, registered
- busy  out  1  high in RAMP or HOLD, registered
- done  out  1  one-cycle pulse on HOLD→IDLE, registered
- pal_idx  out  3  index of the next palette entry to be auto-loaded

## Operation
- States: IDLE, RAMP, HOLD. Registers: tgt (24b), step counter cnt (width clog2(STEP_DIV)), hold counter hcnt, pal_idx.
- Palette: 0 FF0000, 1 FFFF00, 2 00FF00, 3 00FFFF, 4 0000FF, 5 FF00FF, 6 FFFFFF, 7 000000.
- IDLE:
  - tgt_valid && tgt_ready: latch tgt_rgb → RAMP.
  - Else if auto_en: latch palette[pal_idx]; pal_idx ← pal_idx+1, wrapping 7→0; → RAMP.
  - External load has priority over auto. On an external load, pal_idx does not change.
- RAMP:
  - cnt clears on entry, counts 0..STEP_DIV-1, then wraps. tick = (cnt==STEP_DIV-1).
  - On tick, each channel independently moves ±1 toward its target and stops when equal. Unsigned 8-bit arithmetic, no overflow possible.
  - When all three channels equal tgt (checked every cycle, including the entry cycle) → HOLD.
  - A channel's step and the equality check on the same edge: the state changes on the next cycle.
- HOLD:
  - cnt and hcnt clear on entry. hcnt increments on each tick.
  - When hcnt==HOLD_STEPS-1 and tick: done=1 for one cycle → IDLE.
  - Outputs remain constant in HOLD.
- tgt_valid while not IDLE: ignored (ready=0); the source must keep it asserted.
- auto_en deassert during RAMP/HOLD: the current sequence completes; no new auto load follows.
- RST at any time, including mid-RAMP/HOLD: at the next edge, state=IDLE, r/g/b_out=0, busy=0, done=0, pal_idx=0, cnt=hcnt=0, tgt=0.

## Timing
- Reset values: r_out=g_out=b_out=0x00, busy=0, done=0, pal_idx=0. tgt_ready=0 while RST is high and 1 the cycle after release.
- Load accepted at edge N: busy=1 and state=RAMP from N+1.
- First channel change is visible STEP_DIV cycles after RAMP entry.
- Ramp of max channel delta D takes D·STEP_DIV cycles, then 1 cycle to enter HOLD.
- HOLD lasts HOLD_STEPS·STEP_DIV cycles. done is high on the edge where the state returns to IDLE; busy=0 on the same cycle.
- Target equal to current: RAMP lasts 1 cycle, then HOLD.
- Earliest next load: the cycle after done, since tgt_ready=1 in IDLE.
- With auto_en held high, back-to-back sequences have one IDLE cycle between them.
- Maximum full sequence: 255·STEP_DIV + 1 + HOLD_STEPS·STEP_DIV + 1 cycles.

## Test plan
All scenarios use STEP_DIV=4 and HOLD_STEPS=2.
- Reset: assert RST for 3 cycles mid-activity, then release -> outputs 000000, busy=0, done=0, pal_idx=0; tgt_ready=1 the cycle after release.
- Ramp up: load 100005 from 000000 -> b_out reaches 05 at 20 cycles and r_out reaches 10 at 64 cycles after RAMP entry; HOLD lasts 8 cycles; single done pulse; busy falls with done.
- Ramp mixed: from 100005 load 000305 -> r decrements and g increments on the same ticks; b is constant; g=03 at 12 cycles, r=00 at 64 cycles; done fires once.
- Equal target: load 000305 while at 000305 -> RAMP for 1 cycle, HOLD for 8, done; outputs never change.
- Auto cycle with auto_en=1 -> targets in order FF0000, FFFF00, …, 000000, then FF0000 again; pal_idx wraps 7→0. With tgt_valid=1 and tgt_rgb=123456 in the same IDLE cycle -> external target loaded and pal_idx unchanged.
- Reset mid-RAMP at r_out=40 -> next cycle all outputs 0, state IDLE, no done pulse.
